fifo_burst_reader: RTL and testbench
====================================

FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 Parameter DATA_W, default 4, width of data words.
REQ-002 Parameter BURST_LEN, default 4, words per burst; legal range 1..DEPTH of attached FIFO.
REQ-003 Parameter TIMEOUT, default 16, idle cycles with partial data before a single-word flush; legal range >=2.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rstn  input  1  asynchronous, active-low reset.
REQ-006 i_en  input  1  enables starting new bursts or flushes.
REQ-007 i_empty  input  1  FIFO empty flag.
REQ-008 i_alm_empty  input  1  FIFO almost-empty flag; FIFO LOW_TH shall be set to BURST_LEN at integration.
REQ-009 i_rddata  input  DATA_W  FIFO head word, valid same cycle whenever i_empty=0 (show-ahead).
REQ-010 o_rden  output  1  FIFO read enable; pops the head at the next clk edge.
REQ-011 o_valid  output  1  stream word valid.
REQ-012 o_data  output  DATA_W  stream word.
REQ-013 o_last  output  1  marks final word of a burst or flush packet.
REQ-014 i_ready  input  1  downstream accepts when o_valid&i_ready.
REQ-015 o_busy  output  1  high whenever state is not IDLE.

Function
REQ-016 The block SHALL contain a 2-entry output skid buffer {data,last} with registered occupancy occ (0..2); o_valid=(occ!=0); o_data/o_last from buffer head.
REQ-017 o_rden SHALL be asserted iff state is BURST or FLUSH, beats_left>0, i_empty=0 and occ<2 (registered occ only; no combinational path from i_ready to o_rden).
REQ-018 A word popped at edge N SHALL appear on o_data (if buffer was empty, or after earlier words) from cycle N+1; order strictly preserved.
REQ-019 Simultaneous push and pop with occ=1 SHALL keep occ=1, sustaining one word per cycle.
REQ-020 States SHALL be IDLE, BURST, FLUSH.
REQ-021 IDLE->BURST when i_en=1 and i_alm_empty=0; beats_left loaded with BURST_LEN, timeout counter cleared.
REQ-022 IDLE timeout counter (width $clog2(TIMEOUT+1)) SHALL increment each cycle with i_en=1, i_empty=0, i_alm_empty=1; clear whenever i_empty=1 or i_en=0.
REQ-023 IDLE->FLUSH when counter equals TIMEOUT-1 and increment condition holds; beats_left loaded with 1, counter cleared.
REQ-024 BURST->IDLE, FLUSH->IDLE on the edge that pops the final word (beats_left 1->0).
REQ-025 If the FIFO empties mid-burst, o_rden SHALL deassert and state SHALL remain BURST until data returns; no timeout in BURST.
REQ-026 Pushed word SHALL carry last=1 iff beats_left=1 at the pop (final burst word, or the single flush word).
REQ-027 i_en deassertion mid-burst SHALL NOT truncate; the burst completes, then no new burst starts.
REQ-028 BURST_LEN=1 SHALL yield every word tagged last.
REQ-029 IDLE condition checks SHALL give BURST priority over FLUSH when both hold in the same cycle.
REQ-030 o_valid SHALL hold with o_data/o_last stable until accepted (no drop, no change while i_ready=0).

Reset
REQ-031 rstn=0 SHALL asynchronously force state=IDLE, occ=0, beats_left=0, timeout counter=0, buffer data/last=0.
REQ-032 During reset: o_rden=0, o_valid=0, o_data=0, o_last=0, o_busy=0.
REQ-033 Reset asserted mid-burst SHALL discard buffered words; after release the block restarts from IDLE with no spurious o_rden in the first cycle.

Verification
REQ-034 FIFO holds 0x1..0x4, i_en=1, i_ready=1 -> 4 consecutive o_rden pulses, o_data 1,2,3,4 on consecutive cycles, o_last only on 4, then IDLE.
REQ-035 FIFO holds 8 words, i_ready held 0 -> exactly 2 pops, o_valid=1, o_data stuck at first word; i_ready=1 resumes, two bursts of 4 with o_last on words 4 and 8.
REQ-036 FIFO holds 2 words (i_alm_empty=1), i_ready=1 -> after 16 IDLE cycles FLUSH pops word 1 with o_last=1; 16 cycles later word 2 flushed with o_last=1.
REQ-037 Burst starts with 4 words present, FIFO drained externally to empty after 2 pops -> o_rden low, o_busy=1 until 2 more words arrive, then words 3,4 with last on 4.
REQ-038 rstn pulsed low after second pop of a burst -> outputs 0 immediately (asynchronous), buffer empty, next burst begins cleanly from IDLE.
REQ-039 i_ready toggled randomly 50% over 64 words -> output sequence equals FIFO input sequence, o_last every 4th word.

Source files
------------

// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - show-ahead FIFO reader emitting fixed-length bursts or timed single-word flushes
module fifo_burst_reader #(
    parameter int DATA_W    = 4,
    parameter int BURST_LEN = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_en,
    input  logic              i_empty,
    input  logic              i_alm_empty,
    input  logic [DATA_W-1:0] i_rddata,
    output logic              o_rden,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_last,
    input  logic              i_ready,
    output logic              o_busy
);

    localparam int BW = $clog2(BURST_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BURST = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    logic [1:0]        state;
    logic [BW-1:0]     beats_left;
    logic [TW-1:0]     tmo_cnt;
    logic [1:0]        occ;
    logic [DATA_W-1:0] buf0_data;
    logic [DATA_W-1:0] buf1_data;
    logic              buf0_last;
    logic              buf1_last;

    logic push;
    logic pop;
    logic push_last;
    logic tmo_inc;

    // Reads are gated by registered occupancy only, so i_ready never reaches o_rden.
    assign o_rden    = ((state == S_BURST) || (state == S_FLUSH)) && (beats_left != '0)
                       && !i_empty && (occ != 2'd2);
    assign push      = o_rden;
    assign pop       = (occ != 2'd0) && i_ready;
    assign push_last = (beats_left == BW'(1));
    assign tmo_inc   = i_en && !i_empty && i_alm_empty;

    assign o_valid = (occ != 2'd0);
    assign o_data  = buf0_data;
    assign o_last  = buf0_last;
    assign o_busy  = (state != S_IDLE);

    // Burst/flush sequencing: count beats out, and age partial FIFO contents while idle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            beats_left <= '0;
            tmo_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_en && !i_alm_empty) begin
                        state      <= S_BURST;
                        beats_left <= BW'(BURST_LEN);
                        tmo_cnt    <= '0;
                    end else if (tmo_inc) begin
                        if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                            state      <= S_FLUSH;
                            beats_left <= BW'(1);
                            tmo_cnt    <= '0;
                        end else begin
                            tmo_cnt <= tmo_cnt + TW'(1);
                        end
                    end else begin
                        tmo_cnt <= '0;
                    end
                end
                S_BURST, S_FLUSH: begin
                    if (o_rden) begin
                        beats_left <= beats_left - BW'(1);
                        if (beats_left == BW'(1)) begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Two-entry skid buffer; buf0 is the head presented downstream.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            occ       <= 2'd0;
            buf0_data <= '0;
            buf0_last <= 1'b0;
            buf1_data <= '0;
            buf1_last <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        buf0_data <= i_rddata;
                        buf0_last <= push_last;
                    end else begin
                        buf1_data <= i_rddata;
                        buf1_last <= push_last;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    buf0_data <= buf1_data;
                    buf0_last <= buf1_last;
                    occ       <= occ - 2'd1;
                end
                2'b11: begin
                    // push needs occ<2 and pop needs occ>0, so occ is 1: replace the head in place
                    buf0_data <= i_rddata;
                    buf0_last <= push_last;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb/tb_fifo_burst_reader.sv - directed self-checking bench for fifo_burst_reader
module tb_fifo_burst_reader;

    logic       clk = 1'b0;
    logic       rstn;
    logic       i_en;
    logic       i_empty = 1'b1;
    logic       i_alm_empty = 1'b1;
    logic [3:0] i_rddata = 4'h0;
    logic       o_rden;
    logic       o_valid;
    logic [3:0] o_data;
    logic       o_last;
    logic       i_ready;
    logic       o_busy;

    int checks = 0;
    int errors = 0;
    int pops = 0;
    int cyc = 0;

    logic [3:0] fifo[$];
    logic [3:0] out_d[$];
    logic       out_l[$];
    int         out_c[$];
    logic [3:0] exp_d[$];

    fifo_burst_reader #(.DATA_W(4), .BURST_LEN(4), .TIMEOUT(16)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .i_en        (i_en),
        .i_empty     (i_empty),
        .i_alm_empty (i_alm_empty),
        .i_rddata    (i_rddata),
        .o_rden      (o_rden),
        .o_valid     (o_valid),
        .o_data      (o_data),
        .o_last      (o_last),
        .i_ready     (i_ready),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    // FIFO model: pop on read enable, count pops, and time-stamp cycles
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (o_rden) begin
            pops <= pops + 1;
            if (fifo.size() > 0) void'(fifo.pop_front());
        end
    end

    // FIFO flags settle just after the falling edge, once the bench has pushed/drained
    always begin
        @(negedge clk);
        #1;
        i_empty     = (fifo.size() == 0);
        i_alm_empty = (fifo.size() < 4);
        i_rddata    = (fifo.size() > 0) ? fifo[0] : 4'h0;
    end

    // Downstream sink records every accepted word
    always @(posedge clk) begin
        if (rstn && o_valid && i_ready) begin
            out_d.push_back(o_data);
            out_l.push_back(o_last);
            out_c.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_out(input string tag, input int n, input int bound);
        int k;
        k = 0;
        while (out_d.size() < n && k < bound) begin
            tick(1);
            k++;
        end
        chk(tag, (out_d.size() >= n), 1);
    endtask

    task automatic wait_pops(input string tag, input int base, input int n, input int bound);
        int k;
        k = 0;
        while ((pops - base) < n && k < bound) begin
            tick(1);
            k++;
        end
        chk(tag, pops - base, n);
    endtask

    task automatic clear_out();
        out_d.delete();
        out_l.delete();
        out_c.delete();
    endtask

    initial begin
        int p0;
        rstn    = 1'b0;
        i_en    = 1'b0;
        i_ready = 1'b0;
        tick(2);
        chk("rst_rden",  o_rden,  0);
        chk("rst_valid", o_valid, 0);
        chk("rst_data",  o_data,  0);
        chk("rst_last",  o_last,  0);
        chk("rst_busy",  o_busy,  0);
        rstn = 1'b1;
        tick(2);

        // single burst of four with downstream always ready
        clear_out();
        p0 = pops;
        fifo.push_back(4'h1); fifo.push_back(4'h2); fifo.push_back(4'h3); fifo.push_back(4'h4);
        i_en    = 1'b1;
        i_ready = 1'b1;
        wait_out("b1_wait", 4, 40);
        tick(3);
        chk("b1_pops", pops - p0, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("b1_data%0d", i), out_d[i], i + 1);
            chk($sformatf("b1_last%0d", i), out_l[i], (i == 3));
        end
        chk("b1_back2back", out_c[3] - out_c[0], 3);
        chk("b1_idle", o_busy, 0);
        chk("b1_valid", o_valid, 0);

        // backpressure: two pops fill the skid buffer, then two bursts drain
        clear_out();
        i_ready = 1'b0;
        p0 = pops;
        for (int i = 5; i <= 12; i++) fifo.push_back(4'(i));
        tick(10);
        chk("bp_pops", pops - p0, 2);
        chk("bp_valid", o_valid, 1);
        chk("bp_data", o_data, 4'h5);
        tick(3);
        chk("bp_data_hold", o_data, 4'h5);
        chk("bp_busy", o_busy, 1);
        i_ready = 1'b1;
        wait_out("bp_wait", 8, 60);
        tick(3);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("bp_data%0d", i), out_d[i], i + 5);
            chk($sformatf("bp_last%0d", i), out_l[i], (i == 3 || i == 7));
        end
        chk("bp_idle", o_busy, 0);

        // partial contents flushed one word at a time after the idle timeout
        clear_out();
        p0 = pops;
        fifo.push_back(4'hA); fifo.push_back(4'hB);
        tick(15);
        chk("fl1_not_yet", o_busy, 0);
        chk("fl1_no_pop", pops - p0, 0);
        tick(1);
        chk("fl1_busy", o_busy, 1);
        tick(1);
        chk("fl1_valid", o_valid, 1);
        chk("fl1_data", o_data, 4'hA);
        chk("fl1_last", o_last, 1);
        chk("fl1_back_idle", o_busy, 0);
        tick(15);
        chk("fl2_not_yet", o_busy, 0);
        tick(1);
        chk("fl2_busy", o_busy, 1);
        tick(1);
        chk("fl2_data", o_data, 4'hB);
        chk("fl2_last", o_last, 1);
        tick(2);
        chk("fl_count", out_d.size(), 2);
        chk("fl_pops", pops - p0, 2);

        // FIFO drained mid-burst: reader stalls in BURST, then completes
        clear_out();
        p0 = pops;
        fifo.push_back(4'h1); fifo.push_back(4'h2); fifo.push_back(4'h3); fifo.push_back(4'h4);
        wait_pops("dr_two", p0, 2, 20);
        fifo.delete();
        tick(5);
        chk("dr_rden", o_rden, 0);
        chk("dr_busy", o_busy, 1);
        chk("dr_pops", pops - p0, 2);
        fifo.push_back(4'h7); fifo.push_back(4'h8);
        wait_out("dr_wait", 4, 30);
        tick(2);
        chk("dr_d2", out_d[2], 4'h7);
        chk("dr_d3", out_d[3], 4'h8);
        chk("dr_l2", out_l[2], 0);
        chk("dr_l3", out_l[3], 1);
        chk("dr_idle", o_busy, 0);

        // asynchronous reset mid-burst discards buffered words
        p0 = pops;
        fifo.push_back(4'h3); fifo.push_back(4'h4); fifo.push_back(4'h5); fifo.push_back(4'h6);
        wait_pops("ar_two", p0, 2, 20);
        rstn = 1'b0;
        #1;
        chk("ar_valid", o_valid, 0);
        chk("ar_data", o_data, 0);
        chk("ar_last", o_last, 0);
        chk("ar_busy", o_busy, 0);
        chk("ar_rden", o_rden, 0);
        tick(1);
        clear_out();
        rstn = 1'b1;
        fifo.push_back(4'h7); fifo.push_back(4'h8);
        #1;
        chk("ar_rel_rden", o_rden, 0);
        chk("ar_rel_valid", o_valid, 0);
        wait_out("ar_wait", 4, 30);
        tick(2);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ar_data%0d", i), out_d[i], i + 5);
            chk($sformatf("ar_last%0d", i), out_l[i], (i == 3));
        end

        // random backpressure over 64 words
        clear_out();
        exp_d.delete();
        for (int i = 0; i < 64; i++) begin
            exp_d.push_back(4'((i * 7 + 3) & 15));
            fifo.push_back(4'((i * 7 + 3) & 15));
        end
        for (int k = 0; k < 2000 && out_d.size() < 64; k++) begin
            i_ready = 1'($urandom_range(0, 1));
            tick(1);
        end
        i_ready = 1'b1;
        chk("rnd_count", out_d.size(), 64);
        for (int i = 0; i < 64 && i < out_d.size(); i++) begin
            chk($sformatf("rnd_data%0d", i), out_d[i], exp_d[i]);
            chk($sformatf("rnd_last%0d", i), out_l[i], ((i % 4) == 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
